// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory responder.
// Holds the FSM state type, the address/data widths of the core-side and
// external byte-wide interfaces, and the default word returned on a
// timed-out fetch.
package prog_mem_pkg;

  localparam int PROG_ADR_W = 13;
  localparam int PROG_DAT_W = 14;
  localparam int EXT_DAT_W  = 8;

  localparam logic [PROG_DAT_W-1:0] FILL_WORD_DEFAULT = 14'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/prog_byte_timer.sv
// Per-byte-phase wait counter.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   start   - clear the count (beginning of a new byte phase); wins over en
//   en      - count this cycle (a byte phase is in progress)
//   expired - current cycle is the last one allowed for the phase
module prog_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // The count holds the index of the current cycle within the phase, so
  // the final allowed cycle is index TIMEOUT_CYCLES-1.
  assign expired = en && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/prog_mem_responder.sv
// Program-memory responder: serves 14-bit instruction fetches from the core
// out of a one-entry word cache, or by reading two bytes (low then high)
// from a byte-wide external memory, with a per-byte timeout.
// Ports:
//   clk_i, pon_rst_i         - clock, asynchronous active-high reset
//   prog_req_i, prog_adr_i   - fetch request and word address from the core
//   inv_i                    - invalidate the cached word
//   prog_busy_o              - high while a fetch is in progress
//   prog_vld_o, prog_dat_o   - one-cycle result pulse and fetched word
//   prog_err_o               - result pulse came from a timeout
//   ext_rd_o, ext_adr_o      - external byte read strobe and byte address
//   ext_dat_i, ext_ack_i     - external byte data and read completion
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int unsigned            TIMEOUT_CYCLES = 15,
  parameter logic [PROG_DAT_W-1:0]  FILL_WORD      = FILL_WORD_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    pon_rst_i,
  input  logic                    prog_req_i,
  input  logic [PROG_ADR_W-1:0]   prog_adr_i,
  input  logic                    inv_i,
  output logic                    prog_busy_o,
  output logic                    prog_vld_o,
  output logic [PROG_DAT_W-1:0]   prog_dat_o,
  output logic                    prog_err_o,
  output logic                    ext_rd_o,
  output logic [PROG_ADR_W:0]     ext_adr_o,
  input  logic [EXT_DAT_W-1:0]    ext_dat_i,
  input  logic                    ext_ack_i
);

  state_t                  state;
  logic [PROG_ADR_W-1:0]   adr;
  logic [PROG_DAT_W-1:0]   word;
  logic                    cache_vld;
  logic [PROG_ADR_W-1:0]   tag;
  logic [PROG_DAT_W-1:0]   cache_word;
  // Remembers an invalidate seen while the word was being read, so the
  // returned word is not written into the cache.
  logic                    inv_pend;

  logic hit;
  logic tmr_start;
  logic tmr_en;
  logic expired;
  logic [PROG_DAT_W-1:0] hi_word;

  assign hit       = cache_vld && (tag == prog_adr_i) && !inv_i;
  assign tmr_en    = (state == RD_LO) || (state == RD_HI);
  assign tmr_start = ((state == IDLE) && prog_req_i && !hit) ||
                     ((state == RD_LO) && ext_ack_i);
  // Assembled word on the high-byte ack; bits [7:6] of that byte are dropped.
  assign hi_word   = {ext_dat_i[5:0], word[7:0]};

  prog_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk_i),
    .rst     (pon_rst_i),
    .start   (tmr_start),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk_i or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      state       <= IDLE;
      adr         <= '0;
      word        <= '0;
      cache_vld   <= 1'b0;
      tag         <= '0;
      cache_word  <= '0;
      inv_pend    <= 1'b0;
      prog_busy_o <= 1'b0;
      prog_vld_o  <= 1'b0;
      prog_dat_o  <= '0;
      prog_err_o  <= 1'b0;
      ext_rd_o    <= 1'b0;
      ext_adr_o   <= '0;
    end else begin
      if (inv_i) begin
        cache_vld <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (prog_req_i) begin
            adr         <= prog_adr_i;
            inv_pend    <= 1'b0;
            prog_busy_o <= 1'b1;
            if (hit) begin
              state      <= RESP;
              word       <= cache_word;
              prog_dat_o <= cache_word;
              prog_err_o <= 1'b0;
              prog_vld_o <= 1'b1;
            end else begin
              state     <= RD_LO;
              ext_rd_o  <= 1'b1;
              ext_adr_o <= {prog_adr_i, 1'b0};
            end
          end
        end
        RD_LO: begin
          if (inv_i) begin
            inv_pend <= 1'b1;
          end
          if (ext_ack_i) begin
            word[7:0] <= ext_dat_i;
            state     <= RD_HI;
            ext_adr_o <= {adr, 1'b1};
          end else if (expired) begin
            state      <= RESP;
            word       <= FILL_WORD;
            prog_dat_o <= FILL_WORD;
            prog_err_o <= 1'b1;
            prog_vld_o <= 1'b1;
            ext_rd_o   <= 1'b0;
            ext_adr_o  <= '0;
          end
        end
        RD_HI: begin
          if (inv_i) begin
            inv_pend <= 1'b1;
          end
          if (ext_ack_i) begin
            word[13:8] <= ext_dat_i[5:0];
            state      <= RESP;
            prog_dat_o <= hi_word;
            prog_err_o <= 1'b0;
            prog_vld_o <= 1'b1;
            ext_rd_o   <= 1'b0;
            ext_adr_o  <= '0;
            // An invalidate in this same cycle also blocks the write, so
            // cache_vld stays cleared.
            if (!inv_pend && !inv_i) begin
              tag        <= adr;
              cache_word <= hi_word;
              cache_vld  <= 1'b1;
            end
          end else if (expired) begin
            state      <= RESP;
            word       <= FILL_WORD;
            prog_dat_o <= FILL_WORD;
            prog_err_o <= 1'b1;
            prog_vld_o <= 1'b1;
            ext_rd_o   <= 1'b0;
            ext_adr_o  <= '0;
          end
        end
        RESP: begin
          state       <= IDLE;
          prog_vld_o  <= 1'b0;
          prog_err_o  <= 1'b0;
          prog_busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_responder.sv
// Bench for prog_mem_responder: an external byte-memory model with a
// programmable ack delay, and a scoreboard of expected {err, word} results
// popped whenever the responder pulses prog_vld_o.
module tb_prog_mem_responder;

  logic        clk_i = 1'b0;
  logic        pon_rst_i = 1'b1;
  logic        prog_req_i = 1'b0;
  logic [12:0] prog_adr_i = '0;
  logic        inv_i = 1'b0;
  logic        prog_busy_o;
  logic        prog_vld_o;
  logic [13:0] prog_dat_o;
  logic        prog_err_o;
  logic        ext_rd_o;
  logic [13:0] ext_adr_o;
  logic [7:0]  ext_dat_i = '0;
  logic        ext_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  prog_mem_responder #(
    .TIMEOUT_CYCLES (15),
    .FILL_WORD      (14'h0000)
  ) dut (
    .clk_i       (clk_i),
    .pon_rst_i   (pon_rst_i),
    .prog_req_i  (prog_req_i),
    .prog_adr_i  (prog_adr_i),
    .inv_i       (inv_i),
    .prog_busy_o (prog_busy_o),
    .prog_vld_o  (prog_vld_o),
    .prog_dat_o  (prog_dat_o),
    .prog_err_o  (prog_err_o),
    .ext_rd_o    (ext_rd_o),
    .ext_adr_o   (ext_adr_o),
    .ext_dat_i   (ext_dat_i),
    .ext_ack_i   (ext_ack_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] word_of(input logic [7:0] lo, input logic [7:0] hi);
    return {hi[5:0], lo};
  endfunction

  // Scoreboard: {err, word} per expected result pulse.
  logic [14:0] exp_q[$];
  logic [14:0] sb_e;
  int          vld_cnt = 0;

  always @(negedge clk_i) begin
    if (!pon_rst_i && prog_vld_o) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("vld_dat", 32'(prog_dat_o), 32'(sb_e[13:0]));
        chk("vld_err", 32'(prog_err_o), 32'(sb_e[14]));
      end
    end
  end

  // External memory model: acks a byte phase ack_dly cycles after it starts.
  logic [7:0]  lo_byte = 8'h00;
  logic [7:0]  hi_byte = 8'h00;
  int          ack_dly = 1;
  bit          ack_en  = 1'b1;
  int          ph_cnt  = 0;
  logic        last_rd = 1'b0;
  logic [13:0] last_adr = '0;
  logic [13:0] adr_log[$];
  int          rd_cycles = 0;

  always @(negedge clk_i) begin
    if (ext_rd_o) begin
      rd_cycles++;
      if (!last_rd || ext_adr_o != last_adr) begin
        ph_cnt = 0;
        adr_log.push_back(ext_adr_o);
      end else begin
        ph_cnt++;
      end
      ext_ack_i = ack_en && (ph_cnt == ack_dly);
      ext_dat_i = ext_adr_o[0] ? hi_byte : lo_byte;
    end else begin
      ext_ack_i = 1'b0;
      ext_dat_i = 8'h00;
    end
    last_rd  = ext_rd_o;
    last_adr = ext_adr_o;
  end

  task automatic req(input logic [12:0] a);
    @(negedge clk_i);
    prog_adr_i = a;
    prog_req_i = 1'b1;
    @(posedge clk_i);
    #1 prog_req_i = 1'b0;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      lat++;
      if (prog_vld_o) break;
      if (i == 99) chk("vld_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_adr(input string tag, input logic [13:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (ext_rd_o && ext_adr_o == a) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic fetch(input string tag, input logic [12:0] a, input logic [7:0] lo,
                       input logic [7:0] hi, input int dly, input bit en,
                       input logic [14:0] exp, input int exp_lat, input int exp_rd);
    int lat;
    int rd0;
    lo_byte = lo;
    hi_byte = hi;
    ack_dly = dly;
    ack_en  = en;
    exp_q.push_back(exp);
    rd0 = rd_cycles;
    req(a);
    wait_vld(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(prog_busy_o), 32'd1);
    chk({tag, "_rd_cycles"}, 32'(rd_cycles - rd0), 32'(exp_rd));
    @(negedge clk_i);
    chk({tag, "_vld_pulse"}, 32'(prog_vld_o), 32'd0);
    chk({tag, "_hold"}, 32'(prog_dat_o), 32'(exp[13:0]));
    chk({tag, "_idle"}, 32'(prog_busy_o), 32'd0);
  endtask

  initial begin
    int n0;
    int lat;
    int v0;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int lat;
    int v0;

    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(prog_busy_o), 32'd0);
    chk("rst_vld", 32'(prog_vld_o), 32'd0);
    chk("rst_dat", 32'(prog_dat_o), 32'd0);
    chk("rst_err", 32'(prog_err_o), 32'd0);
    chk("rst_rd", 32'(ext_rd_o), 32'd0);
    chk("rst_adr", 32'(ext_adr_o), 32'd0);
    pon_rst_i = 1'b0;

    // Miss, then immediate hit on the same address.
    n0 = adr_log.size();
    fetch("miss", 13'h0123, 8'hA5, 8'hFF, 1, 1'b1, {1'b0, word_of(8'hA5, 8'hFF)}, 5, 4);
    chk("miss_adr_lo", 32'(adr_log[n0]), 32'h0246);
    chk("miss_adr_hi", 32'(adr_log[n0+1]), 32'h0247);
    chk("miss_word", 32'(word_of(8'hA5, 8'hFF)), 32'h3FA5);
    fetch("hit", 13'h0123, 8'h00, 8'h00, 1, 1'b1, {1'b0, 14'h3FA5}, 1, 0);

    // Timeout in the low phase, then the same address must miss.
    fetch("tmo", 13'h0055, 8'h11, 8'h22, 0, 1'b0, {1'b1, 14'h0000}, 16, 15);
    fetch("tmo_retry", 13'h0055, 8'h11, 8'h22, 0, 1'b1, {1'b0, word_of(8'h11, 8'h22)}, 3, 2);

    // Ack in the final allowed cycle of each phase.
    fetch("bnd", 13'h00AA, 8'h3C, 8'h15, 14, 1'b1, {1'b0, word_of(8'h3C, 8'h15)}, 31, 30);

    // Invalidate during the high phase: word returned but not cached.
    lo_byte = 8'h12;
    hi_byte = 8'hC7;
    ack_dly = 3;
    ack_en  = 1'b1;
    v0 = vld_cnt;
    exp_q.push_back({1'b0, word_of(8'h12, 8'hC7)});
    req(13'h1FFF);
    wait_adr("inv_hi_phase", 14'h3FFF);
    inv_i = 1'b1;
    @(negedge clk_i);
    inv_i = 1'b0;
    wait_vld(lat);
    @(negedge clk_i);
    chk("inv_vld_count", 32'(vld_cnt - v0), 32'd1);
    n0 = adr_log.size();
    fetch("inv_refetch", 13'h1FFF, 8'h12, 8'hC7, 1, 1'b1, {1'b0, 14'h0712}, 5, 4);
    chk("inv_adr_lo", 32'(adr_log[n0]), 32'h3FFE);
    chk("inv_adr_hi", 32'(adr_log[n0+1]), 32'h3FFF);
    // 13'h1FFF is now cached; the reset below must forget it.
    fetch("inv_hit", 13'h1FFF, 8'h00, 8'h00, 1, 1'b1, {1'b0, 14'h0712}, 1, 0);

    // Reset in the high phase aborts the fetch silently.
    lo_byte = 8'h5A;
    hi_byte = 8'h3C;
    ack_dly = 3;
    v0 = vld_cnt;
    req(13'h00F1);
    wait_adr("rst_hi_phase", 14'h01E3);
    pon_rst_i = 1'b1;
    #1;
    chk("rst_mid_rd", 32'(ext_rd_o), 32'd0);
    chk("rst_mid_busy", 32'(prog_busy_o), 32'd0);
    chk("rst_mid_adr", 32'(ext_adr_o), 32'd0);
    @(negedge clk_i);
    pon_rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("rst_no_vld", 32'(vld_cnt - v0), 32'd0);
    fetch("rst_cache_gone", 13'h1FFF, 8'h12, 8'hC7, 1, 1'b1, {1'b0, 14'h0712}, 5, 4);
    n0 = adr_log.size();
    fetch("rst_refetch", 13'h00F1, 8'h5A, 8'h3C, 1, 1'b1, {1'b0, word_of(8'h5A, 8'h3C)}, 5, 4);
    chk("rst_adr_lo", 32'(adr_log[n0]), 32'h01E2);
    chk("rst_adr_hi", 32'(adr_log[n0+1]), 32'h01E3);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
